// File: rtl/irq_controller.sv
// irq_controller
//   Parametrised interrupt aggregator for the 65C02 bus. Collects up to 32
//   active-low peripheral interrupt lines, each in level or falling-edge
//   mode with its own enable, and drives the single active-low CPU IRQ.
//
// Parameters
//   NUM_IRQ      number of interrupt inputs (1..32)
//   SYNC_STAGES  synchronizer depth on irqb (2..3)
//
// Ports
//   clk          CPU bus clock (clk_2), rising edge
//   resetb       asynchronous active-low reset
//   cs, rwb      chip select / read-not-write; writes on clk when cs && !rwb
//   addr[2:0]    register index
//   i_data[7:0]  write data
//   o_data[7:0]  read data, combinational from addr and state
//   irqb[N-1:0]  peripheral interrupt lines, active low, asynchronous
//   irqb_master  CPU IRQ, active low, registered
//
// Register map (bank-indexed registers cover channels bank*8 .. bank*8+7)
//   0 VECTOR(R)/ACK(W)  1 BANK  2 ENABLE  3 MODE  4 PENDING(R, W1C)
//   5 RAW(R)  6 FORCE(W)  7 CTRL
module irq_controller #(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               cs,
  input  logic               rwb,
  input  logic [2:0]         addr,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  input  logic [NUM_IRQ-1:0] irqb,
  output logic               irqb_master
);

  typedef enum logic [2:0] {
    REG_VECTOR  = 3'd0,
    REG_BANK    = 3'd1,
    REG_ENABLE  = 3'd2,
    REG_MODE    = 3'd3,
    REG_PENDING = 3'd4,
    REG_RAW     = 3'd5,
    REG_FORCE   = 3'd6,
    REG_CTRL    = 3'd7
  } reg_e;

  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_pending;
  logic [1:0]         r_bank;
  logic               r_ctrl_en;
  logic               r_irqb_master;

  logic               w_wr;
  logic [NUM_IRQ-1:0] w_sync_last;
  logic [NUM_IRQ-1:0] w_asserted;
  logic [NUM_IRQ-1:0] w_fall;
  logic [NUM_IRQ-1:0] w_bank_sel;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_ack_sel;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic               w_vec_any;
  logic [4:0]         w_vec_idx;
  logic [4:0]         w_base;
  logic [31:0]        w_enable32;
  logic [31:0]        w_mode32;
  logic [31:0]        w_pending32;
  logic [31:0]        w_raw32;

  assign w_wr        = cs & ~rwb;
  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_asserted  = ~w_sync_last;
  // History holds the previous synchronized value, so a fall is 1 -> 0.
  assign w_fall      = r_hist & ~w_sync_last;

  // Per-channel decode: which channels the current bank covers, the write
  // data bit that lands on each channel, and the ACK target. Channels at
  // or above NUM_IRQ do not exist, so writes and ACKs to them fall away.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_bank_sel = '0;
    w_wdata    = '0;
    w_ack_sel  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_bank_sel[i] = (i[4:3] == r_bank);
      w_wdata[i]    = i_data[i[2:0]];
      w_ack_sel[i]  = (i_data[4:0] == i[4:0]);
    end
  end

  always_comb begin
    w_set = w_fall;
    w_clr = '0;
    if (w_wr && addr == REG_FORCE)   w_set = w_set | (w_bank_sel & w_wdata);
    if (w_wr && addr == REG_VECTOR)  w_clr = w_clr | w_ack_sel;
    if (w_wr && addr == REG_PENDING) w_clr = w_clr | (w_bank_sel & w_wdata);
    // Level channels mirror the input; edge channels hold until cleared and
    // a set in the same cycle as a clear wins.
    w_pending_nxt = (~r_mode & w_asserted) |
                    (r_mode & (w_set | (r_pending & ~w_clr)));
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_vec_any = 1'b0;
    w_vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pending[i] && r_enable[i]) begin
        w_vec_any = 1'b1;
        w_vec_idx = i[4:0];
      end
    end
  end

  // NOTE: the synchronizer array is reset along with everything else; its
  // flops start deasserted so reset release cannot fake a falling edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
      r_hist        <= '1;
      r_enable      <= '0;
      r_mode        <= '0;
      r_pending     <= '0;
      r_bank        <= '0;
      r_ctrl_en     <= 1'b0;
      r_irqb_master <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, so the shift chain moves one stage per clock.
      r_sync[0] <= irqb;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist    <= w_sync_last;
      r_pending <= w_pending_nxt;
      if (w_wr && addr == REG_BANK)   r_bank    <= i_data[1:0];
      if (w_wr && addr == REG_CTRL)   r_ctrl_en <= i_data[0];
      if (w_wr && addr == REG_ENABLE)
        r_enable <= (r_enable & ~w_bank_sel) | (w_wdata & w_bank_sel);
      if (w_wr && addr == REG_MODE)
        r_mode   <= (r_mode & ~w_bank_sel) | (w_wdata & w_bank_sel);
      r_irqb_master <= ~(r_ctrl_en & |(r_pending & r_enable));
    end
  end

  assign irqb_master = r_irqb_master;

  // Zero-extended 32-channel views make the bank window a plain part-select;
  // banks beyond NUM_IRQ read the zero padding.
  assign w_base      = {r_bank, 3'b000};
  assign w_enable32  = 32'(r_enable);
  assign w_mode32    = 32'(r_mode);
  assign w_pending32 = 32'(r_pending);
  assign w_raw32     = 32'(w_asserted);

  always_comb begin
    o_data = 8'h00;
    case (addr)
      REG_VECTOR:  o_data = w_vec_any ? {1'b1, 2'b00, w_vec_idx} : 8'h00;
      REG_BANK:    o_data = {6'b0, r_bank};
      REG_ENABLE:  o_data = w_enable32[w_base +: 8];
      REG_MODE:    o_data = w_mode32[w_base +: 8];
      REG_PENDING: o_data = w_pending32[w_base +: 8];
      REG_RAW:     o_data = w_raw32[w_base +: 8];
      REG_FORCE:   o_data = 8'h00;
      REG_CTRL:    o_data = {7'b0, r_ctrl_en};
      default:     o_data = 8'h00;
    endcase
  end

endmodule
